// File: rtl/ds18b20_seq_if.sv
`default_nettype none
// ============================================================================
// ds18b20_seq_if : command/response handshake to the 1-Wire byte engine
// Rev 1.0
// ============================================================================
interface ds18b20_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_presence
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_presence
  );
endinterface
`default_nettype wire

// File: rtl/ds18b20_seq.sv
`default_nettype none
// ============================================================================
// ds18b20_seq : DS18B20 measurement sequencer (convert, read scratchpad, CRC8)
// Rev 1.0
// ============================================================================
module ds18b20_seq #(
  parameter int CLK_HZ    = 24_000_000,
  parameter int CONV_US   = 750_000,
  parameter int PERIOD_MS = 1000,
  parameter int MAX_RETRY = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_auto_en,
  input  wire logic          i_start,
  ds18b20_seq_if.master      bus_m,
  output logic               o_busy,
  output logic [15:0]        o_temp_raw,
  output logic               o_temp_valid,
  output logic               o_err_presence,
  output logic               o_err_crc,
  output logic [7:0]         o_err_cnt
);

  localparam int          c_US_DIV      = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam logic [31:0] c_US_LAST     = 32'(c_US_DIV - 1);
  localparam logic [31:0] c_PERIOD_LAST = 32'(PERIOD_MS * 1000 - 1);
  localparam logic [31:0] c_CONV_LAST   = 32'(CONV_US - 1);
  localparam logic [7:0]  c_MAX_RETRY   = 8'(MAX_RETRY);

  localparam logic [1:0]  c_OP_RST = 2'd0;
  localparam logic [1:0]  c_OP_WR  = 2'd1;
  localparam logic [1:0]  c_OP_RD  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RST1  = 4'd1,
    S_SKIP1 = 4'd2,
    S_CONV  = 4'd3,
    S_WAIT  = 4'd4,
    S_RST2  = 4'd5,
    S_SKIP2 = 4'd6,
    S_RDCMD = 4'd7,
    S_RDB   = 4'd8,
    S_CHECK = 4'd9,
    S_FAIL  = 4'd10
  } state_t;

  // Dallas/Maxim CRC8, reflected polynomial 0x8C, data consumed LSB first.
  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [31:0] r_us_cnt;
  logic [31:0] r_period_cnt;
  logic        w_tick;
  logic        w_period_tick;

  state_t      r_state, w_state_nxt;
  logic        r_cmd_valid, w_cmd_valid_nxt;
  logic [1:0]  r_cmd_op, w_cmd_op_nxt;
  logic [7:0]  r_cmd_data, w_cmd_data_nxt;
  logic        r_pending, w_pending_nxt;
  logic [3:0]  r_byte_idx, w_byte_idx_nxt;
  logic [7:0]  r_crc, w_crc_nxt;
  logic [7:0]  r_b0, w_b0_nxt;
  logic [7:0]  r_b1, w_b1_nxt;
  logic [7:0]  r_b8, w_b8_nxt;
  logic [7:0]  r_retries, w_retries_nxt;
  logic        r_cause_crc, w_cause_crc_nxt;
  logic [31:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [15:0] r_temp_raw, w_temp_raw_nxt;
  logic        r_temp_valid, w_temp_valid_nxt;
  logic        r_err_presence, w_err_presence_nxt;
  logic        r_err_crc, w_err_crc_nxt;
  logic [7:0]  r_err_cnt, w_err_cnt_nxt;

  logic [1:0]  w_op;
  logic [7:0]  w_data;
  logic        w_is_cmd;
  logic        w_accept;
  logic        w_rsp;

  // Free-running microsecond tick and auto-mode period counter.
  assign w_tick        = (r_us_cnt == c_US_LAST);
  assign w_period_tick = i_auto_en && w_tick && (r_period_cnt == c_PERIOD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_us_cnt     <= '0;
      r_period_cnt <= '0;
    end else begin
      r_us_cnt <= w_tick ? '0 : r_us_cnt + 32'd1;
      if (!i_auto_en)
        r_period_cnt <= '0;
      else if (w_tick)
        r_period_cnt <= (r_period_cnt == c_PERIOD_LAST) ? '0 : r_period_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cmd_valid    <= 1'b0;
      r_cmd_op       <= 2'd0;
      r_cmd_data     <= 8'h00;
      r_pending      <= 1'b0;
      r_byte_idx     <= 4'd0;
      r_crc          <= 8'h00;
      r_b0           <= 8'h00;
      r_b1           <= 8'h00;
      r_b8           <= 8'h00;
      r_retries      <= 8'd0;
      r_cause_crc    <= 1'b0;
      r_wait_cnt     <= '0;
      r_temp_raw     <= 16'h0000;
      r_temp_valid   <= 1'b0;
      r_err_presence <= 1'b0;
      r_err_crc      <= 1'b0;
      r_err_cnt      <= 8'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cmd_valid    <= w_cmd_valid_nxt;
      r_cmd_op       <= w_cmd_op_nxt;
      r_cmd_data     <= w_cmd_data_nxt;
      r_pending      <= w_pending_nxt;
      r_byte_idx     <= w_byte_idx_nxt;
      r_crc          <= w_crc_nxt;
      r_b0           <= w_b0_nxt;
      r_b1           <= w_b1_nxt;
      r_b8           <= w_b8_nxt;
      r_retries      <= w_retries_nxt;
      r_cause_crc    <= w_cause_crc_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_temp_raw     <= w_temp_raw_nxt;
      r_temp_valid   <= w_temp_valid_nxt;
      r_err_presence <= w_err_presence_nxt;
      r_err_crc      <= w_err_crc_nxt;
      r_err_cnt      <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cmd_valid_nxt    = r_cmd_valid;
    w_cmd_op_nxt       = r_cmd_op;
    w_cmd_data_nxt     = r_cmd_data;
    w_pending_nxt      = r_pending;
    w_byte_idx_nxt     = r_byte_idx;
    w_crc_nxt          = r_crc;
    w_b0_nxt           = r_b0;
    w_b1_nxt           = r_b1;
    w_b8_nxt           = r_b8;
    w_retries_nxt      = r_retries;
    w_cause_crc_nxt    = r_cause_crc;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_temp_raw_nxt     = r_temp_raw;
    w_temp_valid_nxt   = 1'b0;
    w_err_presence_nxt = r_err_presence;
    w_err_crc_nxt      = r_err_crc;
    w_err_cnt_nxt      = r_err_cnt;
    w_op               = c_OP_RST;
    w_data             = 8'h00;
    w_is_cmd           = 1'b0;

    case (r_state)
      S_RST1, S_RST2:   begin w_is_cmd = 1'b1; w_op = c_OP_RST;                 end
      S_SKIP1, S_SKIP2: begin w_is_cmd = 1'b1; w_op = c_OP_WR; w_data = 8'hCC; end
      S_CONV:           begin w_is_cmd = 1'b1; w_op = c_OP_WR; w_data = 8'h44; end
      S_RDCMD:          begin w_is_cmd = 1'b1; w_op = c_OP_WR; w_data = 8'hBE; end
      S_RDB:            begin w_is_cmd = 1'b1; w_op = c_OP_RD;                  end
      default:          ;
    endcase

    // A response is only accepted once its command is accepted (same cycle allowed).
    w_accept = r_cmd_valid && bus_m.cmd_ready;
    w_rsp    = w_is_cmd && bus_m.rsp_valid && (r_pending || w_accept);

    if (w_is_cmd) begin
      if (!r_cmd_valid && !r_pending) begin
        w_cmd_valid_nxt = 1'b1;
        w_cmd_op_nxt    = w_op;
        w_cmd_data_nxt  = w_data;
      end
      if (w_accept) begin
        w_cmd_valid_nxt = 1'b0;
        w_pending_nxt   = 1'b1;
      end
      if (w_rsp)
        w_pending_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (i_start || w_period_tick)
          w_state_nxt = S_RST1;
      end
      S_RST1, S_RST2: begin
        if (w_rsp) begin
          if (!bus_m.rsp_presence) begin
            w_cause_crc_nxt = 1'b0;
            w_state_nxt     = S_FAIL;
          end else begin
            w_state_nxt = (r_state == S_RST1) ? S_SKIP1 : S_SKIP2;
          end
        end
      end
      S_SKIP1: if (w_rsp) w_state_nxt = S_CONV;
      S_CONV: begin
        if (w_rsp) begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tick) begin
          if (r_wait_cnt == c_CONV_LAST) w_state_nxt = S_RST2;
          else                           w_wait_cnt_nxt = r_wait_cnt + 32'd1;
        end
      end
      S_SKIP2: if (w_rsp) w_state_nxt = S_RDCMD;
      S_RDCMD: begin
        if (w_rsp) begin
          w_byte_idx_nxt = 4'd0;
          w_crc_nxt      = 8'h00;
          w_state_nxt    = S_RDB;
        end
      end
      S_RDB: begin
        // CRC accumulates over bytes 0..7 as they arrive; byte 8 is the reference.
        if (w_rsp) begin
          if (r_byte_idx == 4'd0) w_b0_nxt = bus_m.rsp_data;
          if (r_byte_idx == 4'd1) w_b1_nxt = bus_m.rsp_data;
          if (r_byte_idx == 4'd8) begin
            w_b8_nxt    = bus_m.rsp_data;
            w_state_nxt = S_CHECK;
          end else begin
            w_crc_nxt      = f_crc8(r_crc, bus_m.rsp_data);
            w_byte_idx_nxt = r_byte_idx + 4'd1;
          end
        end
      end
      S_CHECK: begin
        if (r_crc == r_b8) begin
          w_temp_raw_nxt     = {r_b1, r_b0};
          w_temp_valid_nxt   = 1'b1;
          w_err_presence_nxt = 1'b0;
          w_err_crc_nxt      = 1'b0;
          w_retries_nxt      = 8'd0;
          w_state_nxt        = S_IDLE;
        end else begin
          w_cause_crc_nxt = 1'b1;
          w_state_nxt     = S_FAIL;
        end
      end
      S_FAIL: begin
        w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
        if (r_retries < c_MAX_RETRY) begin
          w_retries_nxt = r_retries + 8'd1;
          w_state_nxt   = S_RST1;
        end else begin
          if (r_cause_crc) w_err_crc_nxt      = 1'b1;
          else             w_err_presence_nxt = 1'b1;
          w_retries_nxt = 8'd0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus_m.cmd_valid = r_cmd_valid;
  assign bus_m.cmd_op    = r_cmd_op;
  assign bus_m.cmd_data  = r_cmd_data;

  assign o_busy          = (r_state != S_IDLE);
  assign o_temp_raw      = r_temp_raw;
  assign o_temp_valid    = r_temp_valid;
  assign o_err_presence  = r_err_presence;
  assign o_err_crc       = r_err_crc;
  assign o_err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ds18b20_seq.sv
`default_nettype none
// ============================================================================
// tb_ds18b20_seq : directed bench with a reactive 1-Wire byte-engine model
// Rev 1.0
// ============================================================================
module tb_ds18b20_seq;

  localparam int CLK_HZ     = 4_000_000;
  localparam int CONV_US    = 20;
  localparam int PERIOD_MS  = 1;
  localparam int MAX_RETRY  = 3;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int PERIOD_CYC = PERIOD_MS * 1000 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_auto_en = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy;
  logic [15:0] o_temp_raw;
  logic        o_temp_valid;
  logic        o_err_presence;
  logic        o_err_crc;
  logic [7:0]  o_err_cnt;

  ds18b20_seq_if bus ();

  ds18b20_seq #(
    .CLK_HZ(CLK_HZ), .CONV_US(CONV_US), .PERIOD_MS(PERIOD_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_auto_en(i_auto_en), .i_start(i_start), .bus_m(bus),
    .o_busy(o_busy), .o_temp_raw(o_temp_raw), .o_temp_valid(o_temp_valid),
    .o_err_presence(o_err_presence), .o_err_crc(o_err_crc), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Engine model: reacts on the falling edge so the DUT samples stable inputs.
  logic       e_ready = 1'b0;
  logic       e_rsp_valid = 1'b0;
  logic [7:0] e_rsp_data = 8'h00;
  logic       e_presence = 1'b0;
  assign bus.cmd_ready    = e_ready;
  assign bus.rsp_valid    = e_rsp_valid;
  assign bus.rsp_data     = e_rsp_data;
  assign bus.rsp_presence = e_presence;

  logic [7:0] rd_bytes [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
  int         ready_delay = 0;
  bit         same_cyc = 1'b0;
  bit         corrupt = 1'b0;
  int         pres_fail_at = -1;
  int         rst_ops = 0;
  int         rd_idx = 0;
  int         viol = 0;
  int         ready_cnt = 0;
  bit         eng_pend = 1'b0;
  bit         prev_held = 1'b0;
  bit         prev_acc = 1'b0;
  bit         acc;
  logic [1:0] prev_op;
  logic [7:0] prev_data;
  logic [1:0] pend_op;
  logic [9:0] cmd_log [$];
  int         log_cyc [$];

  task automatic eng_rsp(input logic [1:0] op);
    e_rsp_valid = 1'b1;
    if (op == 2'd0) begin
      e_presence = (rst_ops != pres_fail_at);
      rst_ops++;
    end else if (op == 2'd2) begin
      if (rd_idx == 8) e_rsp_data = corrupt ? 8'h1D : rd_bytes[8];
      else             e_rsp_data = rd_bytes[rd_idx];
      if (rd_idx < 8) rd_idx++;
    end
  endtask

  always @(negedge clk) begin
    acc = 1'b0;
    e_ready = 1'b0;
    e_rsp_valid = 1'b0;
    e_rsp_data = 8'h00;
    e_presence = 1'b0;
    if (!rst_n) begin
      eng_pend = 1'b0; ready_cnt = 0; prev_held = 1'b0; prev_acc = 1'b0; rd_idx = 0;
    end else begin
      if (prev_held && (!bus.cmd_valid || bus.cmd_op != prev_op || bus.cmd_data != prev_data)) viol++;
      if (prev_acc && bus.cmd_valid) viol++;
      if (eng_pend && bus.cmd_valid) viol++;
      if (eng_pend) begin
        eng_rsp(pend_op);
        eng_pend = 1'b0;
      end else if (bus.cmd_valid) begin
        if (ready_cnt < ready_delay) begin
          ready_cnt++;
        end else begin
          ready_cnt = 0;
          e_ready = 1'b1;
          acc = 1'b1;
          cmd_log.push_back({bus.cmd_op, bus.cmd_data});
          log_cyc.push_back(cyc);
          if (bus.cmd_op == 2'd0) rd_idx = 0;
          if (same_cyc) eng_rsp(bus.cmd_op);
          else begin eng_pend = 1'b1; pend_op = bus.cmd_op; end
        end
      end
      prev_held = bus.cmd_valid && !acc;
      prev_acc  = acc;
      prev_op   = bus.cmd_op;
      prev_data = bus.cmd_data;
    end
  end

  int start_times [$];
  int tv_cnt = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (o_busy && !prev_busy) start_times.push_back(cyc);
    prev_busy = o_busy;
    if (o_temp_valid) tv_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    bit to;
    to = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (!o_busy) begin to = 1'b0; break; end
    end
    chk_eq(tag, 32'(to), 32'd0);
  endtask

  logic [9:0] exp_seq [15];
  int b, t0, v0, s0, dw;
  bit to;

  initial begin
    exp_seq[0] = {2'd0, 8'h00}; exp_seq[1] = {2'd1, 8'hCC}; exp_seq[2] = {2'd1, 8'h44};
    exp_seq[3] = {2'd0, 8'h00}; exp_seq[4] = {2'd1, 8'hCC}; exp_seq[5] = {2'd1, 8'hBE};
    for (int i = 6; i < 15; i++) exp_seq[i] = {2'd2, 8'h00};

    // Reset state
    #12;
    chk_eq("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk_eq("rst_busy", 32'(o_busy), 32'd0);
    chk_eq("rst_temp_raw", 32'(o_temp_raw), 32'd0);
    chk_eq("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    chk_eq("rst_err_flags", 32'({o_err_presence, o_err_crc, o_temp_valid}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good measurement, command order, conversion wait, start latency
    b = cmd_log.size(); t0 = tv_cnt; v0 = viol;
    pulse_start();
    chk_eq("start_busy", 32'(o_busy), 32'd1);
    chk_eq("start_valid_c1", 32'(bus.cmd_valid), 32'd0);
    @(negedge clk);
    chk_eq("start_valid_c2", 32'(bus.cmd_valid), 32'd1);
    wait_idle("good_timeout", 3000);
    chk_eq("good_cmd_count", 32'(cmd_log.size() - b), 32'd15);
    for (int i = 0; i < 15; i++) chk_eq($sformatf("good_cmd%0d", i), 32'(cmd_log[b + i]), 32'(exp_seq[i]));
    dw = log_cyc[b + 3] - log_cyc[b + 2] - 1;
    chk_eq("conv_wait_in_window", 32'(dw >= CONV_US * DIV - DIV && dw <= (CONV_US + 1) * DIV + 2), 32'd1);
    chk_eq("good_temp_raw", 32'(o_temp_raw), 32'h0550);
    chk_eq("good_tv_pulses", 32'(tv_cnt - t0), 32'd1);
    chk_eq("good_err_cnt", 32'(o_err_cnt), 32'd0);
    chk_eq("good_err_flags", 32'({o_err_presence, o_err_crc}), 32'd0);
    chk_eq("good_handshake_viol", 32'(viol - v0), 32'd0);

    // CRC failure on every attempt
    corrupt = 1'b1;
    b = cmd_log.size(); t0 = tv_cnt;
    pulse_start();
    wait_idle("crc_timeout", 5000);
    chk_eq("crc_cmd_count", 32'(cmd_log.size() - b), 32'd60);
    chk_eq("crc_err_cnt", 32'(o_err_cnt), 32'd4);
    chk_eq("crc_err_crc", 32'(o_err_crc), 32'd1);
    chk_eq("crc_err_presence", 32'(o_err_presence), 32'd0);
    chk_eq("crc_temp_unchanged", 32'(o_temp_raw), 32'h0550);
    chk_eq("crc_tv_pulses", 32'(tv_cnt - t0), 32'd0);
    corrupt = 1'b0;

    // Presence failure on the first bus reset only
    pres_fail_at = rst_ops;
    b = cmd_log.size(); t0 = tv_cnt;
    pulse_start();
    wait_idle("pres_timeout", 3000);
    chk_eq("pres_cmd_count", 32'(cmd_log.size() - b), 32'd16);
    chk_eq("pres_retry_is_reset", 32'(cmd_log[b + 1]), 32'({2'd0, 8'h00}));
    chk_eq("pres_err_cnt", 32'(o_err_cnt), 32'd5);
    chk_eq("pres_err_flags", 32'({o_err_presence, o_err_crc}), 32'd0);
    chk_eq("pres_tv_pulses", 32'(tv_cnt - t0), 32'd1);

    // Slow acceptance plus response in the acceptance cycle
    ready_delay = 50; same_cyc = 1'b1;
    b = cmd_log.size(); t0 = tv_cnt; v0 = viol;
    pulse_start();
    wait_idle("slow_timeout", 5000);
    chk_eq("slow_handshake_viol", 32'(viol - v0), 32'd0);
    chk_eq("slow_cmd_count", 32'(cmd_log.size() - b), 32'd15);
    chk_eq("slow_cmd_rdcmd", 32'(cmd_log[b + 5]), 32'({2'd1, 8'hBE}));
    chk_eq("slow_tv_pulses", 32'(tv_cnt - t0), 32'd1);
    chk_eq("slow_temp_raw", 32'(o_temp_raw), 32'h0550);
    ready_delay = 0; same_cyc = 1'b0;

    // Auto mode: exact period, start while busy ignored, auto_en=0 stops
    s0 = start_times.size(); b = cmd_log.size(); t0 = tv_cnt;
    i_auto_en = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 3 * PERIOD_CYC; i++) begin
      @(negedge clk); #1;
      if (start_times.size() >= s0 + 2) begin to = 1'b0; break; end
    end
    chk_eq("auto_two_starts_timeout", 32'(to), 32'd0);
    repeat (5) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2 * PERIOD_CYC; i++) begin
      @(negedge clk); #1;
      if (start_times.size() >= s0 + 3) begin to = 1'b0; break; end
    end
    chk_eq("auto_third_start_timeout", 32'(to), 32'd0);
    wait_idle("auto_idle_timeout", 3000);
    i_auto_en = 1'b0;
    chk_eq("auto_spacing1", 32'(start_times[s0 + 1] - start_times[s0]), 32'(PERIOD_CYC));
    chk_eq("auto_spacing2", 32'(start_times[s0 + 2] - start_times[s0 + 1]), 32'(PERIOD_CYC));
    chk_eq("auto_cmd_count", 32'(cmd_log.size() - b), 32'd45);
    chk_eq("auto_tv_pulses", 32'(tv_cnt - t0), 32'd3);
    repeat (2 * PERIOD_CYC + 100) @(negedge clk);
    chk_eq("auto_off_no_start", 32'(start_times.size() - s0), 32'd3);

    // Asynchronous reset in the middle of the scratchpad reads
    b = cmd_log.size();
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (cmd_log.size() - b >= 11) begin to = 1'b0; break; end
    end
    chk_eq("mid_rdb_timeout", 32'(to), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("arst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk_eq("arst_cmd_op_data", 32'({bus.cmd_op, bus.cmd_data}), 32'd0);
    chk_eq("arst_busy", 32'(o_busy), 32'd0);
    chk_eq("arst_temp_raw", 32'(o_temp_raw), 32'd0);
    chk_eq("arst_err_cnt", 32'(o_err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b = cmd_log.size(); t0 = tv_cnt;
    pulse_start();
    wait_idle("post_rst_timeout", 3000);
    chk_eq("post_rst_cmd_count", 32'(cmd_log.size() - b), 32'd15);
    chk_eq("post_rst_first_cmd", 32'(cmd_log[b]), 32'({2'd0, 8'h00}));
    chk_eq("post_rst_temp_raw", 32'(o_temp_raw), 32'h0550);
    chk_eq("post_rst_tv_pulses", 32'(tv_cnt - t0), 32'd1);
    chk_eq("post_rst_err_cnt", 32'(o_err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ds18b20_seq.md
# ds18b20_seq

Transaction sequencer for the DS18B20 temperature path. It drives a byte-level 1-Wire engine through a command/response handshake. Each measurement runs reset, SKIP ROM, CONVERT T, a conversion wait, reset, SKIP ROM, READ SCRATCHPAD and nine byte reads. It then checks the scratchpad CRC8 and publishes the raw temperature with a valid strobe. The block sits between the 1-Wire engine, which owns the dq pin and bit timing, and the display/UART consumers. It also handles periodic triggering, presence/CRC retry and error reporting.

## Interface
- CLK_HZ, 24_000_000: clk frequency; derives the internal 1 µs tick (CLK_HZ/1_000_000 cycles).
- CONV_US, 750_000: conversion wait in µs, measured after the CONVERT T response.
- PERIOD_MS, 1000: auto-mode measurement period in ms, start to start.
- MAX_RETRY, 3: retries after a failed attempt before reporting an error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- auto_en  in  1  when 1, start a measurement every PERIOD_MS.
- start  in  1  one-cycle pulse; start a measurement if idle, otherwise ignore.
- cmd_valid  out  1  command request to the engine.
- cmd_ready  in  1  engine accepts the command on the cycle where cmd_valid&&cmd_ready.
- cmd_op  out  2  0 = bus reset/presence, 1 = write byte, 2 = read byte.
- cmd_data  out  8  byte to write; 0 for other ops.
- rsp_valid  in  1  one-cycle completion strobe for the outstanding command.
- rsp_data  in  8  byte read (op 2).
- rsp_presence  in  1  presence detected (op 0).
- busy  out  1  measurement in progress.
- temp_raw  out  16  {scratchpad byte1, byte0} from the last good read.
- temp_valid  out  1  one-cycle pulse when temp_raw updates.
- err_presence  out  1  sticky; set on final presence failure, cleared on next good read.
- err_crc  out  1  sticky; set on final CRC failure, cleared on next good read.
- err_cnt  out  8  count of failed attempts, saturates at 255.

## Operation
- States: IDLE, RST1, SKIP1, CONV, WAIT, RST2, SKIP2, RDCMD, RDB, CHECK, FAIL.
- IDLE → RST1 on start, or on the period tick when auto_en=1.
- Command states issue one command, then wait for rsp_valid, then advance:
  - RST1 issues (0,0x00) and goes to SKIP1.
  - SKIP1 issues (1,0xCC) and goes to CONV.
  - CONV issues (1,0x44) and goes to WAIT.
  - WAIT counts CONV_US ticks and goes to RST2.
  - RST2 issues (0,0x00) and goes to SKIP2.
  - SKIP2 issues (1,0xCC) and goes to RDCMD.
  - RDCMD issues (1,0xBE) and goes to RDB.
  - RDB issues (2,0x00) nine times, storing bytes 0..8, then goes to CHECK.
- In RST1/RST2, a response with rsp_presence=0 sends the FSM to FAIL.
- CHECK: run Dallas CRC8 (poly x^8+x^5+x^4+1, reflected 0x8C, init 0x00, LSB-first) over bytes 0..7 and compare with byte 8.
  - Match: load temp_raw={b1,b0}, pulse temp_valid, clear both err flags, reset the retry count, go to IDLE.
  - Mismatch: go to FAIL.
- CRC may be computed incrementally as bytes arrive or serially in CHECK. Either way, CHECK lasts at most 16 cycles.
- FAIL:
  - err_cnt += 1 (saturating).
  - If retries < MAX_RETRY: increment retries and go to RST1.
  - Otherwise: set err_presence or err_crc according to the cause, reset retries, go to IDLE. temp_raw is unchanged.
- busy = (state != IDLE).
- The period counter runs continuously while auto_en=1 and is cleared when auto_en=0. A tick that arrives while busy is dropped, not queued.

## Timing
- Reset values: cmd_valid=0, cmd_op=0, cmd_data=0, busy=0, temp_raw=0, temp_valid=0, err_presence=0, err_crc=0, err_cnt=0, state=IDLE, retries=0.
- Handshake:
  - cmd_valid rises the cycle after entering a command state.
  - cmd_op/cmd_data stay stable while cmd_valid=1.
  - cmd_valid drops the cycle after acceptance.
  - At most one command is outstanding.
  - rsp_valid is ignored unless a response is awaiting.
  - rsp_valid in the same cycle as acceptance is legal and is honoured.
- The start → RST1 command issue takes 2 cycles.
- The last RDB response → temp_valid takes ≤ 17 cycles.
- The WAIT exit occurs within one tick of CONV_US µs after the CONVERT response.
- Reset mid-measurement aborts immediately to the reset values. The engine is reset by the same rst_n.
- A start pulse coinciding with a period tick produces one measurement.

## Test plan
- Start with a presence-OK engine model returning 50 05 4B 46 7F FF 0C 10 1C:
  - Command order must be R,CC,44,(CONV_US wait),R,CC,BE, then 9 reads.
  - Then temp_raw=0x0550, exactly one temp_valid pulse, err_cnt=0.
- Byte 8 corrupted to 0x1D on every attempt:
  - Expect 4 full attempts, err_cnt=4, err_crc=1, temp_raw unchanged.
- rsp_presence=0 on the first RST1 only:
  - Expect one retry, a good read, err_cnt=1, err_presence=0.
- cmd_ready held low for 50 cycles:
  - cmd_valid/cmd_op/cmd_data stay stable, with no duplicate issue.
  - With rsp_valid in the acceptance cycle, the FSM still advances.
- auto_en=1 with PERIOD_MS shortened for simulation:
  - Starts occur at exact period spacing.
  - A start pulse while busy is ignored.
  - auto_en=0 stops further starts.
- rst_n asserted during RDB byte 4:
  - All outputs return to reset values asynchronously and cmd_valid=0.
  - The next start runs a full clean sequence.
